// File: rtl/core_task_fifo.sv
// core_task_fifo: first-word fall-through queue of core IDs.
// Storage is a DEPTH-entry register array addressed by read/write pointers
// that carry an extra wrap bit, so full and empty are told apart without a
// separate occupancy counter.
// Optional feature: define CORE_TASK_FIFO_DUP_FILTER_EN to add a per-core
// pending bitmap that drops enqueues of IDs already waiting in the queue.
module core_task_fifo #(
    parameter  int CORES = 4,
    parameter  int DEPTH = 8,
    localparam int IDW   = $clog2(CORES),
    localparam int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDW-1:0]  enq_id,
    input  logic            enq_valid,
    output logic            enq_ready,
    output logic [IDW-1:0]  deq_id,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty,
    output logic            dup_drop
);

    // Index width; the pointer MSB above it is the wrap bit.
    localparam int AW = CNTW - 1;

    logic [CNTW-1:0] wptr_q, wptr_d;
    logic [CNTW-1:0] rptr_q, rptr_d;
    logic [IDW-1:0]  mem_q [DEPTH];

    logic enq_fire;
    logic deq_fire;
    logic wr_en;

    // Occupancy flags come straight from registered pointers, so enq_ready
    // never depends on a same-cycle dequeue.
    assign full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty     = (wptr_q == rptr_q);
    assign count     = wptr_q - rptr_q;
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_id    = mem_q[rptr_q[AW-1:0]];

    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

`ifdef CORE_TASK_FIFO_DUP_FILTER_EN
    logic [CORES-1:0] pend_q, pend_d;
    logic             dup;
    logic             dup_drop_q;

    // An ID leaving this very cycle is not a duplicate of an arriving one.
    assign dup      = pend_q[enq_id] && !(deq_fire && (deq_id == enq_id));
    assign wr_en    = enq_fire && !dup;
    assign dup_drop = dup_drop_q;

    // Pending bitmap next state: clear on dequeue first, then set on write,
    // so a same-cycle leave/arrive of one ID leaves its bit set.
    always_comb begin
        pend_d = pend_q;
        if (deq_fire) begin
            pend_d[deq_id] = 1'b0;
        end
        if (wr_en) begin
            pend_d[enq_id] = 1'b1;
        end
    end

    // Pending bitmap and one-cycle duplicate-drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            dup_drop_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            dup_drop_q <= enq_fire && dup;
        end
    end
`else
    assign wr_en    = enq_fire;
    assign dup_drop = 1'b0;
`endif

    // Pointer next state: advance by one (mod 2*DEPTH) on each handshake.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + CNTW'(1);
        end
        if (deq_fire) begin
            rptr_d = rptr_q + CNTW'(1);
        end
    end

    // Pointer registers; reset wins over any concurrent handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= enq_id;
        end
    end

endmodule
